// File: rtl/aes_key_expander_if.sv
// rtl/aes_key_expander_if.sv - key-load, status and round-key read signals of the AES key expander
interface aes_key_expander_if;
  logic [1:0]  key_size;
  logic        key_start;
  logic [31:0] key_in;
  logic        key_in_valid;
  logic        key_in_ready;
  logic        busy;
  logic        key_done;
  logic        key_err;
  logic [5:0]  round_words;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic        rd_inv;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (
    output key_size, key_start, key_in, key_in_valid, rd_en, rd_addr, rd_inv,
    input  key_in_ready, busy, key_done, key_err, round_words, rd_data, rd_valid
  );

  modport slave (
    input  key_size, key_start, key_in, key_in_valid, rd_en, rd_addr, rd_inv,
    output key_in_ready, busy, key_done, key_err, round_words, rd_data, rd_valid
  );
endinterface

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - iterative AES-128/192/256 key schedule with a registered round-key read port
module aes_key_expander_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX_TABLE[din];
endmodule

module aes_key_expander_imc (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] x1 [4];
  logic [7:0] x9 [4];
  logic [7:0] xb [4];
  logic [7:0] xd [4];
  logic [7:0] xe [4];

  for (genvar k = 0; k < 4; k++) begin : g_byte
    logic [7:0] x2, x4, x8;
    assign x1[k] = din[31-8*k -: 8];
    assign x2    = xt(x1[k]);
    assign x4    = xt(x2);
    assign x8    = xt(x4);
    assign x9[k] = x8 ^ x1[k];
    assign xb[k] = x8 ^ x2 ^ x1[k];
    assign xd[k] = x8 ^ x4 ^ x1[k];
    assign xe[k] = x8 ^ x4 ^ x2;
  end

  assign dout = {xe[0] ^ xb[1] ^ xd[2] ^ x9[3],
                 x9[0] ^ xe[1] ^ xb[2] ^ xd[3],
                 xd[0] ^ x9[1] ^ xe[2] ^ xb[3],
                 xb[0] ^ xd[1] ^ x9[2] ^ xe[3]};
endmodule

module aes_key_expander #(
  parameter int SBOX_LANES = 1,
  parameter bit RD_INV_EN  = 1'b1
) (
  input logic               CLK,
  input logic               RST,
  aes_key_expander_if.slave kx
);
  localparam int SUB_CYCLES = 4 / SBOX_LANES;
  localparam int CW         = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, FETCH, SUB, WRITE, DONE} state_t;

  state_t        state;
  logic [31:0]   mem [64];
  logic [31:0]   mem_q;
  logic [5:0]    idx;
  logic [3:0]    nk;
  logic [2:0]    pos;
  logic [3:0]    rnd;
  logic [31:0]   temp;
  logic [CW-1:0] sub_cnt;
  logic          rd_pend;
  logic          rd_inv_sel;

  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic          mem_re;
  logic [5:0]    mem_raddr;
  logic [31:0]   w_next;
  logic [31:0]   sub_next;
  logic [31:0]   imc_out;
  logic          rd_accept;
  logic          inv_ok;
  logic          pos_wrap;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // One lane substitutes the top byte and rotates, so after four passes the word is back in order.
  if (SBOX_LANES == 4) begin : g_sub4
    for (genvar b = 0; b < 4; b++) begin : g_lane
      aes_key_expander_sbox u_sbox (.din(temp[8*b +: 8]), .dout(sub_next[8*b +: 8]));
    end
  end else begin : g_sub1
    logic [7:0] s;
    aes_key_expander_sbox u_sbox (.din(temp[31:24]), .dout(s));
    assign sub_next = {temp[23:0], s};
  end

  if (RD_INV_EN) begin : g_imc
    aes_key_expander_imc u_imc (.din(mem_q), .dout(imc_out));
  end else begin : g_no_imc
    assign imc_out = mem_q;
  end

  assign w_next    = mem_q ^ temp;
  assign pos_wrap  = ({1'b0, pos} == nk - 4'd1);
  assign rd_accept = !RST && !kx.key_start && kx.rd_en && kx.key_done && (state == DONE);
  // The first and last round keys are never run through InvMixColumns in the equivalent inverse cipher.
  assign inv_ok    = RD_INV_EN && kx.rd_inv && (kx.rd_addr >= 6'd4) &&
                     (kx.rd_addr <= kx.round_words - 6'd5);
  assign mem_re    = (state == FETCH) || rd_accept;
  assign mem_raddr = (state == FETCH) ? (idx - {2'b00, nk}) : kx.rd_addr;

  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = kx.key_in;
    if (!RST && !kx.key_start) begin
      if (state == LOAD && kx.key_in_valid) begin
        mem_we = 1'b1;
      end else if (state == WRITE) begin
        mem_we    = 1'b1;
        mem_wdata = w_next;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[idx] <= mem_wdata;
    if (mem_re) mem_q <= mem[mem_raddr];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= IDLE;
      kx.key_in_ready <= 1'b0;
      kx.busy         <= 1'b0;
      kx.key_done     <= 1'b0;
      kx.key_err      <= 1'b0;
      kx.rd_valid     <= 1'b0;
      kx.rd_data      <= 32'h0;
      kx.round_words  <= 6'd0;
      idx             <= 6'd0;
      nk              <= 4'd4;
      pos             <= 3'd0;
      rnd             <= 4'd0;
      temp            <= 32'h0;
      sub_cnt         <= '0;
      rd_pend         <= 1'b0;
      rd_inv_sel      <= 1'b0;
    end else begin
      kx.rd_valid <= rd_pend;
      if (rd_pend) kx.rd_data <= rd_inv_sel ? imc_out : mem_q;
      rd_pend    <= rd_accept;
      rd_inv_sel <= inv_ok;

      if (kx.key_start) begin
        idx         <= 6'd0;
        pos         <= 3'd0;
        rnd         <= 4'd0;
        sub_cnt     <= '0;
        kx.key_done <= 1'b0;
        if (kx.key_size == 2'b11) begin
          state           <= IDLE;
          kx.key_err      <= 1'b1;
          kx.busy         <= 1'b0;
          kx.key_in_ready <= 1'b0;
        end else begin
          state           <= LOAD;
          kx.key_err      <= 1'b0;
          kx.busy         <= 1'b1;
          kx.key_in_ready <= 1'b1;
          case (kx.key_size)
            2'b00:   begin nk <= 4'd4; kx.round_words <= 6'd44; end
            2'b01:   begin nk <= 4'd6; kx.round_words <= 6'd52; end
            default: begin nk <= 4'd8; kx.round_words <= 6'd60; end
          endcase
        end
      end else begin
        case (state)
          LOAD: begin
            if (kx.key_in_valid) begin
              temp <= kx.key_in;
              idx  <= idx + 6'd1;
              if (pos_wrap) begin
                pos <= 3'd0;
                rnd <= rnd + 4'd1;
              end else begin
                pos <= pos + 3'd1;
              end
              if (idx + 6'd1 == {2'b00, nk}) begin
                state           <= FETCH;
                kx.key_in_ready <= 1'b0;
              end
            end
          end
          FETCH: begin
            sub_cnt <= '0;
            if (pos == 3'd0) begin
              temp  <= {temp[23:0], temp[31:24]};
              state <= SUB;
            end else if (nk == 4'd8 && pos == 3'd4) begin
              state <= SUB;
            end else begin
              state <= WRITE;
            end
          end
          SUB: begin
            if (sub_cnt == CW'(SUB_CYCLES - 1)) begin
              temp  <= sub_next ^ ((pos == 3'd0) ? {rcon(rnd), 24'h0} : 32'h0);
              state <= WRITE;
            end else begin
              temp    <= sub_next;
              sub_cnt <= sub_cnt + 1'b1;
            end
          end
          WRITE: begin
            temp <= w_next;
            idx  <= idx + 6'd1;
            if (pos_wrap) begin
              pos <= 3'd0;
              rnd <= rnd + 4'd1;
            end else begin
              pos <= pos + 3'd1;
            end
            if (idx + 6'd1 == kx.round_words) begin
              state       <= DONE;
              kx.busy     <= 1'b0;
              kx.key_done <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - directed-vector bench driving SBOX_LANES=4 and SBOX_LANES=1 engines in lockstep
module tb_aes_key_expander;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] key [8];

  aes_key_expander_if kx4();
  aes_key_expander_if kx1();

  aes_key_expander #(.SBOX_LANES(4), .RD_INV_EN(1'b1)) dut4 (.CLK(CLK), .RST(RST), .kx(kx4));
  aes_key_expander #(.SBOX_LANES(1), .RD_INV_EN(1'b1)) dut1 (.CLK(CLK), .RST(RST), .kx(kx1));

  assign kx1.key_size     = kx4.key_size;
  assign kx1.key_start    = kx4.key_start;
  assign kx1.key_in       = kx4.key_in;
  assign kx1.key_in_valid = kx4.key_in_valid;
  assign kx1.rd_en        = kx4.rd_en;
  assign kx1.rd_addr      = kx4.rd_addr;
  assign kx1.rd_inv       = kx4.rd_inv;

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix(input logic [31:0] w);
    logic [7:0]  m [4];
    logic [7:0]  o;
    logic [31:0] r;
    m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    r = 32'h0;
    for (int row = 0; row < 4; row++) begin
      o = 8'h00;
      for (int c = 0; c < 4; c++) o = o ^ gmul(w[31-8*c -: 8], m[(c - row + 4) % 4]);
      r[31-8*row -: 8] = o;
    end
    return r;
  endfunction

  function automatic int exp_latency(input int nk, input int lanes);
    int total;
    int cyc;
    total = 4 * (nk + 7);
    cyc = 0;
    for (int i = nk; i < total; i++)
      cyc += ((i % nk == 0) || (nk == 8 && i % nk == 4)) ? 2 + 4 / lanes : 2;
    return cyc;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "/ctl4"}, 32'({kx4.key_in_ready, kx4.busy, kx4.key_done, kx4.key_err, kx4.rd_valid}), 32'h0);
    check_eq({tag, "/ctl1"}, 32'({kx1.key_in_ready, kx1.busy, kx1.key_done, kx1.key_err, kx1.rd_valid}), 32'h0);
    check_eq({tag, "/data4"}, kx4.rd_data, 32'h0);
    check_eq({tag, "/data1"}, kx1.rd_data, 32'h0);
    check_eq({tag, "/rw"}, 32'({kx4.round_words, kx1.round_words}), 32'h0);
  endtask

  task automatic load_key(input logic [1:0] size, input int nk, input int gap);
    @(negedge CLK);
    kx4.key_start = 1'b1;
    kx4.key_size  = size;
    @(negedge CLK);
    kx4.key_start = 1'b0;
    for (int k = 0; k < nk; k++) begin
      kx4.key_in       = key[k];
      kx4.key_in_valid = 1'b1;
      @(negedge CLK);
      kx4.key_in_valid = 1'b0;
      kx4.key_in       = 32'hdeadbeef;
      if (k != nk - 1) repeat (gap) @(negedge CLK);
    end
  endtask

  task automatic expand(input string tag, input logic [1:0] size, input int nk, input int gap);
    int lat4;
    int lat1;
    int cyc;
    load_key(size, nk, gap);
    lat4 = -1;
    lat1 = -1;
    cyc = 0;
    while ((lat4 < 0 || lat1 < 0) && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) check_eq({tag, "/busy"}, 32'({kx4.busy, kx1.busy}), 32'h3);
      if (lat4 < 0 && kx4.key_done) lat4 = cyc;
      if (lat1 < 0 && kx1.key_done) lat1 = cyc;
    end
    check_eq({tag, "/lat4"}, 32'(lat4), 32'(exp_latency(nk, 4)));
    check_eq({tag, "/lat1"}, 32'(lat1), 32'(exp_latency(nk, 1)));
    check_eq({tag, "/rw4"}, 32'(kx4.round_words), 32'(4 * (nk + 7)));
    check_eq({tag, "/rw1"}, 32'(kx1.round_words), 32'(4 * (nk + 7)));
    check_eq({tag, "/idle"}, 32'({kx4.busy, kx1.busy, kx4.key_err, kx1.key_err}), 32'h0);
  endtask

  task automatic read_word(input string tag, input logic [5:0] addr, input logic inv, input logic [31:0] exp);
    @(negedge CLK);
    kx4.rd_en   = 1'b1;
    kx4.rd_addr = addr;
    kx4.rd_inv  = inv;
    @(negedge CLK);
    kx4.rd_en  = 1'b0;
    kx4.rd_inv = 1'b0;
    check_eq({tag, "/early"}, 32'({kx4.rd_valid, kx1.rd_valid}), 32'h0);
    @(negedge CLK);
    check_eq({tag, "/valid"}, 32'({kx4.rd_valid, kx1.rd_valid}), 32'h3);
    check_eq({tag, "/d4"}, kx4.rd_data, exp);
    check_eq({tag, "/d1"}, kx1.rd_data, exp);
  endtask

  task automatic expect_no_read(input string tag);
    @(negedge CLK);
    kx4.rd_en   = 1'b1;
    kx4.rd_addr = 6'd0;
    repeat (2) @(negedge CLK);
    check_eq({tag, "/novalid"}, 32'({kx4.rd_valid, kx1.rd_valid}), 32'h0);
    kx4.rd_en = 1'b0;
    @(negedge CLK);
    check_eq({tag, "/novalid2"}, 32'({kx4.rd_valid, kx1.rd_valid}), 32'h0);
  endtask

  task automatic set_key128;
    key[0] = 32'h2b7e1516; key[1] = 32'h28aed2a6; key[2] = 32'habf71588; key[3] = 32'h09cf4f3c;
  endtask

  task automatic set_key256;
    key[0] = 32'h603deb10; key[1] = 32'h15ca71be; key[2] = 32'h2b73aef0; key[3] = 32'h857d7781;
    key[4] = 32'h1f352c07; key[5] = 32'h3b6108d7; key[6] = 32'h2d9810a3; key[7] = 32'h0914dff4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    kx4.key_size     = 2'b00;
    kx4.key_start    = 1'b0;
    kx4.key_in       = 32'h0;
    kx4.key_in_valid = 1'b0;
    kx4.rd_en        = 1'b0;
    kx4.rd_addr      = 6'd0;
    kx4.rd_inv       = 1'b0;
    for (int k = 0; k < 8; k++) key[k] = 32'h0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b0;

    expect_no_read("pre_key");

    set_key128();
    expand("aes128", 2'b00, 4, 0);
    read_word("w128_0", 6'd0, 1'b0, 32'h2b7e1516);
    read_word("w128_4", 6'd4, 1'b0, 32'ha0fafe17);
    read_word("w128_43", 6'd43, 1'b0, 32'hb6630ca6);
    read_word("inv_0", 6'd0, 1'b1, 32'h2b7e1516);
    read_word("inv_43", 6'd43, 1'b1, 32'hb6630ca6);
    read_word("inv_4", 6'd4, 1'b1, inv_mix(32'ha0fafe17));

    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        kx4.rd_en   = 1'b1;
        kx4.rd_addr = 6'(k);
      end else begin
        kx4.rd_en = 1'b0;
      end
      @(negedge CLK);
      if (k >= 1 && k <= 3) begin
        check_eq("b2b/valid", 32'({kx4.rd_valid, kx1.rd_valid}), 32'h3);
        check_eq("b2b/d4", kx4.rd_data, key[k-1]);
        check_eq("b2b/d1", kx1.rd_data, key[k-1]);
      end
    end

    key[0] = 32'h8e73b0f7; key[1] = 32'hda0e6452; key[2] = 32'hc810f32b;
    key[3] = 32'h809079e5; key[4] = 32'h62f8ead2; key[5] = 32'h522c6b7b;
    expand("aes192_gap", 2'b01, 6, 2);
    read_word("w192_6", 6'd6, 1'b0, 32'hfe0c91f7);
    read_word("w192_51", 6'd51, 1'b0, 32'h01002202);

    set_key256();
    load_key(2'b10, 8, 0);
    repeat (20) @(negedge CLK);
    check_eq("abort/mid", 32'({kx4.key_done, kx1.key_done, kx4.busy, kx1.busy}), 32'h3);
    set_key128();
    expand("abort128", 2'b00, 4, 0);
    read_word("abort_w4", 6'd4, 1'b0, 32'ha0fafe17);
    read_word("abort_w43", 6'd43, 1'b0, 32'hb6630ca6);

    set_key256();
    expand("aes256", 2'b10, 8, 0);
    read_word("w256_8", 6'd8, 1'b0, 32'h9ba35411);
    read_word("w256_12", 6'd12, 1'b0, 32'ha8b09c1a);
    read_word("w256_59", 6'd59, 1'b0, 32'h706c631e);

    @(negedge CLK);
    kx4.key_start = 1'b1;
    kx4.key_size  = 2'b11;
    @(negedge CLK);
    kx4.key_start = 1'b0;
    check_eq("err/flags4", 32'({kx4.key_err, kx4.key_done, kx4.busy}), 32'h4);
    check_eq("err/flags1", 32'({kx1.key_err, kx1.key_done, kx1.busy}), 32'h4);
    expect_no_read("err");

    set_key128();
    load_key(2'b00, 4, 0);
    repeat (2) @(negedge CLK);
    check_eq("rst_sub/busy", 32'({kx4.busy, kx1.busy}), 32'h3);
    RST = 1'b1;
    @(negedge CLK);
    check_reset_outputs("rst_sub");
    RST = 1'b0;
    @(negedge CLK);
    check_eq("rst_sub/stay", 32'({kx4.busy, kx1.busy, kx4.key_done, kx1.key_done}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
